// File: rtl/mem_line_arbiter_pkg.sv
// Shared definitions for the I/D cache line arbiter: line geometry, FSM states
// and requester side encodings.
package mem_line_arbiter_pkg;

  localparam int WORD_SIZE  = 16;
  localparam int LINE_WORDS = 4;
  localparam int LINE_BITS  = WORD_SIZE * LINE_WORDS;
  localparam int ADDR_W     = 16;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

endpackage

// File: rtl/mem_line_arbiter_sat_counter.sv
// Up-counter with synchronous clear and enable that holds at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/mem_line_arbiter.sv
// Round-robin arbiter granting whole-line memory transactions to the I-cache
// refill port or the D-cache refill/writeback port, one at a time.
module mem_line_arbiter
  import mem_line_arbiter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [ADDR_W-1:0]    i_addr,
  output logic                 i_ack,
  output logic [LINE_BITS-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_W-1:0]    d_addr,
  input  logic [LINE_BITS-1:0] d_wdata,
  output logic                 d_ack,
  output logic [LINE_BITS-1:0] d_rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [LINE_BITS-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic [LINE_BITS-1:0] mem_rdata,
  output logic                 busy,
  output logic                 owner,
  output logic [CNT_W-1:0]     i_grants,
  output logic [CNT_W-1:0]     d_grants,
  output logic [1:0]           state_dbg
);

  // Handshakes: a requester holds req high until its one-cycle ack; memory
  // holds ack/rdata for the cycle that completes a level mem_req.

  arb_state_t state, next_state;
  logic                 last;
  logic                 we_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [LINE_BITS-1:0] wdata_q;
  logic [LINE_BITS-1:0] i_rdata_q;
  logic [LINE_BITS-1:0] d_rdata_q;
  logic                 grant;
  logic                 grant_side;

  always_comb begin
    next_state = state;
    grant      = 1'b0;
    grant_side = SIDE_I;
    case (state)
      ARB_IDLE: begin
        if (i_req || d_req) begin
          grant      = 1'b1;
          grant_side = (i_req && d_req) ? ~last : d_req;
          next_state = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        if (mem_ack) next_state = ARB_RESP;
      end
      ARB_RESP: next_state = ARB_IDLE;
      default:  next_state = ARB_IDLE;
    endcase
  end

  // 'last' doubles as the owner of the in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB_IDLE;
      last      <= SIDE_I;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state <= next_state;
      if (grant) begin
        last    <= grant_side;
        we_q    <= (grant_side == SIDE_D) && d_we;
        addr_q  <= (grant_side == SIDE_D) ? {d_addr[ADDR_W-1:2], 2'b00}
                                          : {i_addr[ADDR_W-1:2], 2'b00};
        wdata_q <= (grant_side == SIDE_D) ? d_wdata : '0;
      end
      if ((state == ARB_ACCESS) && mem_ack) begin
        if (last == SIDE_D) d_rdata_q <= we_q ? '0 : mem_rdata;
        else                i_rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_req   = (state == ARB_ACCESS);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_ack     = (state == ARB_RESP) && (last == SIDE_I);
  assign d_ack     = (state == ARB_RESP) && (last == SIDE_D);
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state != ARB_IDLE);
  assign owner     = last;
  assign state_dbg = state;

  sat_counter #(.CNT_W(CNT_W)) u_i_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (grant && (grant_side == SIDE_I)),
    .count (i_grants)
  );

  sat_counter #(.CNT_W(CNT_W)) u_d_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (grant && (grant_side == SIDE_D)),
    .count (d_grants)
  );

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Bench for mem_line_arbiter: directed scenarios then random traffic, checked
// against a transaction-level model of arbitration, latency and counters.
module tb_mem_line_arbiter;
  import mem_line_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic i_req, d_req, d_we, mem_ack;
  logic [15:0] i_addr, d_addr;
  logic [63:0] d_wdata, mem_rdata;
  logic i_ack, d_ack, mem_req, mem_we, busy, owner;
  logic [63:0] i_rdata, d_rdata, mem_wdata;
  logic [15:0] mem_addr, i_grants, d_grants;
  logic [1:0] state_dbg;
  // second instance with 2-bit counters to reach saturation quickly
  logic i_ack_s, d_ack_s, mem_req_s, mem_we_s, busy_s, owner_s;
  logic [63:0] i_rdata_s, d_rdata_s, mem_wdata_s;
  logic [15:0] mem_addr_s;
  logic [1:0] i_grants_s, d_grants_s, state_dbg_s;

  always #5 clk = ~clk;

  mem_line_arbiter #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
    .i_rdata(i_rdata), .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .owner(owner),
    .i_grants(i_grants), .d_grants(d_grants), .state_dbg(state_dbg)
  );

  mem_line_arbiter #(.CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack_s),
    .i_rdata(i_rdata_s), .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack_s), .d_rdata(d_rdata_s), .mem_req(mem_req_s),
    .mem_we(mem_we_s), .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy_s), .owner(owner_s),
    .i_grants(i_grants_s), .d_grants(d_grants_s), .state_dbg(state_dbg_s)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          last_m;
  int          i_cnt_m, d_cnt_m;
  bit          i_pend, d_pend, d_w;
  logic [15:0] i_a, d_a;
  logic [63:0] d_wd, i_rd_m, d_rd_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int n, input int lim);
    return (n > lim) ? lim : n;
  endfunction

  task automatic set_reqs();
    i_req   = i_pend;
    i_addr  = i_a;
    d_req   = d_pend;
    d_we    = d_w;
    d_addr  = d_a;
    d_wdata = d_wd;
  endtask

  task automatic check_counters();
    check("i_grants", i_grants, 64'(sat(i_cnt_m, 65535)));
    check("d_grants", d_grants, 64'(sat(d_cnt_m, 65535)));
    check("i_grants_sat", i_grants_s, 64'(sat(i_cnt_m, 3)));
    check("d_grants_sat", d_grants_s, 64'(sat(d_cnt_m, 3)));
  endtask

  // Entered at a negedge in IDLE with requests driven; returns at the
  // negedge of the IDLE cycle following the ack.
  task automatic do_txn(input int w, input logic [63:0] rd, input bit keep);
    bit side, we;
    logic [15:0] a;
    logic [63:0] wd;
    side = (i_pend && d_pend) ? ~last_m : d_pend;
    a    = side ? d_a : i_a;
    we   = side ? d_w : 1'b0;
    wd   = d_wd;
    last_m = side;
    if (side) d_cnt_m++; else i_cnt_m++;
    @(negedge clk);
    for (int k = 0; k <= w; k++) begin
      check("mem_req", mem_req, 1);
      check("busy", busy, 1);
      check("owner", owner, 64'(side));
      check("mem_addr", mem_addr, {a[15:2], 2'b00});
      check("mem_we", mem_we, 64'(we));
      if (we) check("mem_wdata", mem_wdata, wd);
      check("early_ack", {i_ack, d_ack}, 0);
      if (k == w) begin
        mem_ack   = 1'b1;
        mem_rdata = rd;
      end
      @(negedge clk);
    end
    mem_ack   = 1'b0;
    mem_rdata = {$urandom, $urandom};
    if (side) d_rd_m = we ? 64'd0 : rd;
    else      i_rd_m = rd;
    check("i_ack", i_ack, 64'(!side));
    check("d_ack", d_ack, 64'(side));
    check("resp_mem_req", mem_req, 0);
    check("i_rdata", i_rdata, i_rd_m);
    check("d_rdata", d_rdata, d_rd_m);
    check_counters();
    if (!keep) begin
      if (side) d_pend = 1'b0; else i_pend = 1'b0;
    end
    set_reqs();
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_acks", {i_ack, d_ack}, 0);
    check("idle_rdata_hold", {i_rdata ^ i_rd_m} | {d_rdata ^ d_rd_m}, 0);
  endtask

  // Reset for one edge, check all outputs cleared, then release.
  task automatic do_reset();
    reset   = 1'b1;
    i_pend  = 1'b0;
    d_pend  = 1'b0;
    set_reqs();
    mem_ack = 1'b0;
    @(negedge clk);
    last_m  = 1'b0;
    i_cnt_m = 0;
    d_cnt_m = 0;
    i_rd_m  = '0;
    d_rd_m  = '0;
    check("rst_mem_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_acks", {i_ack, d_ack}, 0);
    check("rst_owner", owner, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check_counters();
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; i_pend = 0; d_pend = 0; i_a = '0; d_a = '0; d_w = 0; d_wd = '0;
    set_reqs();
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    do_reset();

    // single I-side read, zero memory wait
    i_pend = 1; i_a = 16'h0013; set_reqs();
    do_txn(0, 64'h0004_0003_0002_0001, 0);

    // simultaneous requests: D wins the first tie after reset, then I
    do_reset();
    i_pend = 1; i_a = 16'h0100; d_pend = 1; d_a = 16'h0203; d_w = 0; set_reqs();
    do_txn(0, 64'h1111_2222_3333_4444, 0);
    do_txn(1, 64'h5555_6666_7777_8888, 0);

    // D-side writeback with three wait cycles
    d_pend = 1; d_a = 16'h0042; d_w = 1; d_wd = 64'hAAAA_BBBB_CCCC_DDDD; set_reqs();
    do_txn(3, 64'hDEAD_BEEF_0000_1234, 0);

    // both held continuously: strict alternation
    do_reset();
    i_pend = 1; i_a = 16'h0300; d_pend = 1; d_a = 16'h0401; d_w = 0; set_reqs();
    for (int n = 0; n < 6; n++) do_txn(n % 3, {$urandom, $urandom}, 1);
    check("alt_i_grants", i_grants, 3);
    check("alt_d_grants", d_grants, 3);
    i_pend = 0; d_pend = 0; set_reqs();

    // further D grants push the narrow counter past saturation
    for (int n = 0; n < 3; n++) begin
      d_pend = 1; d_a = 16'($urandom); d_w = 1'($urandom); d_wd = {$urandom, $urandom};
      set_reqs();
      do_txn(0, {$urandom, $urandom}, 0);
    end

    // reset during a long ACCESS drops the transaction
    d_pend = 1; d_a = 16'h0500; d_w = 0; set_reqs();
    @(negedge clk);
    repeat (4) begin
      check("pre_rst_mem_req", mem_req, 1);
      @(negedge clk);
    end
    do_reset();
    for (int n = 0; n < 8; n++) begin
      mem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("dropped_acks", {i_ack, d_ack}, 0);
      check("stray_ack_busy", busy, 0);
    end
    mem_ack = 1'b0;

    // random traffic
    for (int n = 0; n < 40; n++) begin
      if (!i_pend && $urandom_range(0, 1) == 1) begin
        i_pend = 1; i_a = 16'($urandom);
      end
      if (!d_pend && $urandom_range(0, 1) == 1) begin
        d_pend = 1; d_a = 16'($urandom); d_w = 1'($urandom); d_wd = {$urandom, $urandom};
      end
      if (!i_pend && !d_pend) begin
        i_pend = 1; i_a = 16'($urandom);
      end
      set_reqs();
      do_txn($urandom_range(0, 3), {$urandom, $urandom}, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
